// File: rtl/imem_load_fetch_ctrl.sv
// ============================================================================
// Module   : imem_load_fetch_ctrl
// Function : Lets a boot loader write the instruction memory, then hands the
//            port to the IF stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_load_fetch_ctrl #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          reload_req,
  input  logic          pc_valid,
  input  logic [31:0]   pc_addr,
  input  logic          fetch_hold,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          fetch_fault,
  output logic          core_run,
  output logic          ld_err,
  output logic [AW:0]   load_count,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [29:0] DEPTH_W   = DEPTH[29:0];
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};

  state_t      state_q, state_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_instr_q, fetch_instr_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        ld_err_q, ld_err_d;
  logic [AW:0] load_count_q, load_count_d;

  logic ld_in_range;
  logic pc_bad;
  logic unused_ld_lsb;

  // Byte offset within a word is meaningless for whole-word loads.
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign ld_in_range = (ld_addr[31:2] < DEPTH_W);
  assign pc_bad      = (|pc_addr[1:0]) | (pc_addr[31:2] >= DEPTH_W);

  always_comb begin
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    fetch_instr_d = fetch_instr_q;
    fetch_fault_d = fetch_fault_q;
    ld_err_d      = ld_err_q;
    load_count_d  = load_count_q;
    ld_ready      = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = pc_addr[AW+1:2];

    case (state_q)
      ST_LOAD: begin
        ld_ready      = 1'b1;
        mem_addr      = ld_addr[AW+1:2];
        fetch_valid_d = 1'b0;
        if (ld_valid) begin
          if (ld_in_range) begin
            mem_we = 1'b1;
            if (load_count_q != DEPTH_CNT) begin
              load_count_d = load_count_q + CNT_ONE;
            end
          end else begin
            ld_err_d = 1'b1;
          end
          // Out-of-range last word still ends the load so a bad image cannot wedge boot.
          if (ld_last) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (reload_req) begin
          state_d       = ST_LOAD;
          fetch_valid_d = 1'b0;
          load_count_d  = '0;
          ld_err_d      = 1'b0;
        end else if (!fetch_hold) begin
          if (pc_valid) begin
            fetch_valid_d = 1'b1;
            fetch_fault_d = pc_bad;
            fetch_instr_d = pc_bad ? 32'h0000_0000 : mem_rdata;
          end else begin
            fetch_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_LOAD;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 32'h0000_0000;
      fetch_fault_q <= 1'b0;
      ld_err_q      <= 1'b0;
      load_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_fault_q <= fetch_fault_d;
      ld_err_q      <= ld_err_d;
      load_count_q  <= load_count_d;
    end
  end

  assign core_run    = (state_q == ST_RUN);
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign ld_err      = ld_err_q;
  assign load_count  = load_count_q;
  assign mem_wdata   = ld_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_load_fetch_ctrl.sv
// ============================================================================
// Module   : tb_imem_load_fetch_ctrl
// Function : Scoreboard bench for the loader/fetch controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_load_fetch_ctrl;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [31:0]   ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          reload_req = 1'b0;
  logic          pc_valid = 1'b0;
  logic [31:0]   pc_addr = '0;
  logic          fetch_hold = 1'b0;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          fetch_fault;
  logic          core_run;
  logic          ld_err;
  logic [AW:0]   load_count;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] mem       [0:DEPTH-1];
  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] words     [0:2];

  logic [31:0] exp_instr_q[$];
  logic        exp_fault_q[$];
  logic        exp_run = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  imem_load_fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .reload_req (reload_req),
    .pc_valid   (pc_valid),
    .pc_addr    (pc_addr),
    .fetch_hold (fetch_hold),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault),
    .core_run   (core_run),
    .ld_err     (ld_err),
    .load_count (load_count),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory macro model: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Fetch monitor: pops one expected result per accepted fetch request.
  initial begin
    logic want, held;
    logic [31:0] ei;
    logic ef;
    forever begin
      @(posedge clk);
      want = rst_n && exp_run && pc_valid && !fetch_hold && !reload_req;
      held = rst_n && exp_run && fetch_hold && !reload_req;
      if (!rst_n) exp_run = 1'b0;
      else if (!exp_run && ld_valid && ld_last) exp_run = 1'b1;
      else if (exp_run && reload_req) exp_run = 1'b0;
      #1;
      if (want) begin
        n_vec++;
        if (exp_instr_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: fetch accepted at %0t with no expectation queued", $time);
        end else begin
          ei = exp_instr_q.pop_front();
          ef = exp_fault_q.pop_front();
          if (fetch_valid !== 1'b1 || fetch_instr !== ei || fetch_fault !== ef) begin
            n_err++;
            $display("FAIL sb_fetch: got v=%b instr=%h fault=%b, want v=1 instr=%h fault=%b at %0t",
                     fetch_valid, fetch_instr, fetch_fault, ei, ef, $time);
          end
        end
      end else if (!held) begin
        n_vec++;
        if (fetch_valid !== 1'b0) begin
          n_err++;
          $display("FAIL sb_idle_valid: got fetch_valid=%b want 0 at %0t", fetch_valid, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    logic bad;
    bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
    exp_instr_q.push_back(bad ? 32'h0 : model_mem[a[11:2]]);
    exp_fault_q.push_back(bad);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL rst_ld_ready: got %b want 1", ld_ready); end
    n_vec++; if (core_run !== 1'b0) begin n_err++; $display("FAIL rst_core_run: got %b want 0", core_run); end
    n_vec++; if (fetch_instr !== 32'h0 || fetch_fault !== 1'b0) begin n_err++;
      $display("FAIL rst_fetch: got instr=%h fault=%b want 0/0", fetch_instr, fetch_fault); end
    n_vec++; if (ld_err !== 1'b0 || load_count !== '0) begin n_err++;
      $display("FAIL rst_ld_state: got err=%b count=%0d want 0/0", ld_err, load_count); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 32'(i * 4);
      ld_data  = words[i];
      ld_last  = (i == 2);
      #1;
      n_vec++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== words[i]) begin n_err++;
        $display("FAIL load_port_%0d: got we=%b addr=%0d wdata=%h want 1/%0d/%h",
                 i, mem_we, mem_addr, mem_wdata, i, words[i]); end
      n_vec++; if (core_run !== 1'b0) begin n_err++; $display("FAIL load_early_run_%0d: got %b want 0", i, core_run); end
      model_mem[i] = words[i];
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    n_vec++; if (core_run !== 1'b1 || ld_ready !== 1'b0) begin n_err++;
      $display("FAIL load_to_run: got core_run=%b ld_ready=%b want 1/0", core_run, ld_ready); end
    n_vec++; if (load_count !== 11'd3 || ld_err !== 1'b0) begin n_err++;
      $display("FAIL load_count: got count=%0d err=%b want 3/0", load_count, ld_err); end
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 32'(i * 4);
      push_fetch(pc_addr);
      #1;
      n_vec++; if (mem_addr !== AW'(i) || mem_we !== 1'b0) begin n_err++;
        $display("FAIL fetch_port_%0d: got addr=%0d we=%b want %0d/0", i, mem_addr, mem_we, i); end
      tick();
    end
    pc_valid = 1'b0;
    tick();
    n_vec++; if (fetch_valid !== 1'b0 || fetch_instr !== words[2]) begin n_err++;
      $display("FAIL fetch_idle_keep: got v=%b instr=%h want 0/%h", fetch_valid, fetch_instr, words[2]); end
  endtask

  task automatic test_hold();
    pc_valid = 1'b1;
    pc_addr  = 32'h0;
    push_fetch(pc_addr);
    tick();
    fetch_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pc_addr = 32'(4 + i * 4);
      tick();
      n_vec++; if (fetch_valid !== 1'b1 || fetch_instr !== words[0]) begin n_err++;
        $display("FAIL hold_freeze_%0d: got v=%b instr=%h want 1/%h", i, fetch_valid, fetch_instr, words[0]); end
    end
    fetch_hold = 1'b0;
    pc_addr    = 32'h8;
    push_fetch(pc_addr);
    tick();
    pc_valid = 1'b0;
    tick();
  endtask

  task automatic test_fault();
    pc_valid = 1'b1;
    pc_addr  = 32'h6;
    push_fetch(pc_addr);
    #1;
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL fault_no_write: got mem_we=%b want 0", mem_we); end
    tick();
    pc_addr = 32'h1000;
    push_fetch(pc_addr);
    tick();
    pc_addr = 32'h4;
    push_fetch(pc_addr);
    tick();
    pc_valid = 1'b0;
    tick();
  endtask

  task automatic test_reload_loader();
    reload_req = 1'b1;
    pc_valid   = 1'b1;
    pc_addr    = 32'h4;
    tick();
    reload_req = 1'b0;
    pc_valid   = 1'b0;
    n_vec++; if (core_run !== 1'b0 || ld_ready !== 1'b1 || load_count !== '0 || ld_err !== 1'b0) begin n_err++;
      $display("FAIL reload_enter: got run=%b rdy=%b count=%0d err=%b want 0/1/0/0",
               core_run, ld_ready, load_count, ld_err); end
    ld_valid = 1'b1;
    ld_addr  = 32'h1000;
    ld_data  = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL oor_write: got mem_we=%b want 0", mem_we); end
    tick();
    n_vec++; if (ld_err !== 1'b1 || load_count !== '0) begin n_err++;
      $display("FAIL oor_err: got err=%b count=%0d want 1/0", ld_err, load_count); end
    ld_addr    = 32'hF;
    ld_data    = 32'h1234_5678;
    reload_req = 1'b1;
    #1;
    n_vec++; if (mem_we !== 1'b1 || mem_addr !== 10'd3) begin n_err++;
      $display("FAIL lsb_ignored: got we=%b addr=%0d want 1/3", mem_we, mem_addr); end
    model_mem[3] = 32'h1234_5678;
    tick();
    reload_req = 1'b0;
    n_vec++; if (load_count !== 11'd1 || ld_err !== 1'b1 || core_run !== 1'b0) begin n_err++;
      $display("FAIL reload_in_load: got count=%0d err=%b run=%b want 1/1/0", load_count, ld_err, core_run); end
    ld_addr = 32'h2000;
    ld_last = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    n_vec++; if (core_run !== 1'b1 || load_count !== 11'd1 || ld_err !== 1'b1) begin n_err++;
      $display("FAIL oor_last_run: got run=%b count=%0d err=%b want 1/1/1", core_run, load_count, ld_err); end
    pc_valid = 1'b1;
    pc_addr  = 32'hC;
    push_fetch(pc_addr);
    tick();
    pc_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midload();
    reload_req = 1'b1;
    pc_valid   = 1'b1;
    pc_addr    = 32'h0;
    tick();
    reload_req = 1'b0;
    pc_valid   = 1'b0;
    n_vec++; if (core_run !== 1'b0 || load_count !== '0 || fetch_valid !== 1'b0) begin n_err++;
      $display("FAIL reload_vs_fetch: got run=%b count=%0d v=%b want 0/0/0", core_run, load_count, fetch_valid); end
    ld_valid = 1'b1;
    ld_addr  = 32'h0;
    ld_data  = 32'hAAAA_0001;
    model_mem[0] = ld_data;
    tick();
    ld_addr = 32'h4;
    ld_data = 32'hBBBB_0002;
    model_mem[1] = ld_data;
    tick();
    n_vec++; if (load_count !== 11'd2) begin n_err++;
      $display("FAIL midload_count: got %0d want 2", load_count); end
    ld_addr = 32'h8;
    ld_data = 32'hCCCC_0003;
    #3;
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    #1;
    n_vec++; if (load_count !== '0 || core_run !== 1'b0 || ld_ready !== 1'b1 || ld_err !== 1'b0) begin n_err++;
      $display("FAIL async_rst_ld: got count=%0d run=%b rdy=%b err=%b want 0/0/1/0",
               load_count, core_run, ld_ready, ld_err); end
    n_vec++; if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || fetch_fault !== 1'b0) begin n_err++;
      $display("FAIL async_rst_fetch: got v=%b instr=%h fault=%b want 0/0/0", fetch_valid, fetch_instr, fetch_fault); end
    tick();
    rst_n = 1'b1;
    tick();
    ld_valid = 1'b1;
    ld_addr  = 32'h40;
    ld_data  = 32'hEEEE_0004;
    ld_last  = 1'b1;
    model_mem[16] = ld_data;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    pc_valid = 1'b1;
    for (int i = 1; i < 3; i++) begin
      pc_addr = 32'(i * 4);
      push_fetch(pc_addr);
      tick();
    end
    pc_addr = 32'h40;
    push_fetch(pc_addr);
    tick();
    pc_valid = 1'b0;
    tick();
    n_vec++; if (exp_instr_q.size() != 0) begin n_err++;
      $display("FAIL sb_leftover: got %0d pending expectations want 0", exp_instr_q.size()); end
  endtask

  initial begin
    words[0] = 32'h8C10_0004;
    words[1] = 32'h0250_8820;
    words[2] = 32'h0250_8822;
    test_reset();
    test_load();
    test_fetch_stream();
    test_hold();
    test_fault();
    test_reload_loader();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_load_fetch_ctrl.md
# imem_load_fetch_ctrl

Controller owning the single port of the word-addressed instruction memory (1024 × 32-bit, byte addresses shifted right by 2, combinational read). After reset, it holds the pipeline off and lets a boot loader write the program through a valid/ready stream. It then switches the port to the IF stage and returns registered instruction words with one-cycle latency. A reload request returns the port to the loader at any time.

## Interface
- DEPTH, 1024: instruction memory depth in 32-bit words; index width AW = clog2(DEPTH).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader may transfer; equals (state == LOAD).
- ld_addr  in  32  loader byte address.
- ld_data  in  32  instruction word to write.
- ld_last  in  1  marks final word of the program.
- reload_req  in  1  single-cycle pulse; re-enter LOAD.
- pc_valid  in  1  IF stage requests fetch at pc_addr.
- pc_addr  in  32  fetch byte address (PC).
- fetch_hold  in  1  pipeline stall; freeze fetch outputs.
- fetch_valid  out  1  fetch_instr valid.
- fetch_instr  out  32  fetched instruction (registered).
- fetch_fault  out  1  registered with fetch_instr; misaligned or out-of-range PC.
- core_run  out  1  high in RUN; core is held in reset while low.
- ld_err  out  1  sticky: an out-of-range loader address was seen since entering LOAD.
- load_count  out  AW+1  in-range words written since entering LOAD; saturates at DEPTH.
- mem_addr  out  AW  word index to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  equals ld_data.
- mem_rdata  in  32  combinational read data at mem_addr.

## Operation
- States: LOAD, RUN. Reset enters LOAD.
- LOAD:
  - ld_ready = 1.
  - mem_addr = ld_addr[AW+1:2].
  - A transfer is ld_valid & ld_ready.
  - In-range transfer (ld_addr>>2 < DEPTH): mem_we = 1, load_count increments (saturating).
  - Out-of-range transfer: mem_we = 0, ld_err set. The transfer is still accepted.
  - ld_addr[1:0] is ignored for writes.
  - A transfer with ld_last = 1 moves to RUN on that edge, whether or not it was in range.
  - pc_valid is ignored; fetch_valid = 0.
- RUN:
  - ld_ready = 0, mem_we = 0, mem_addr = pc_addr[AW+1:2].
  - If pc_valid & !fetch_hold & !reload_req, the next edge loads fetch_valid = 1 and fetch_instr = mem_rdata.
  - If pc_addr[1:0] != 0 or pc_addr>>2 >= DEPTH, the next edge instead loads fetch_instr = 32'h00000000 (NOP) and fetch_fault = 1. Otherwise fetch_fault = 0.
  - If !pc_valid & !fetch_hold, fetch_valid clears and fetch_instr keeps its value.
  - If fetch_hold = 1, fetch_valid, fetch_instr and fetch_fault keep their values.
- reload_req in RUN:
  - Next edge: state = LOAD, core_run = 0, fetch_valid = 0, load_count = 0, ld_err = 0.
  - Takes priority over a same-cycle fetch and over fetch_hold.
- reload_req in LOAD: ignored (count and error retained).
- Memory contents are never cleared by this block.

## Timing
- Reset values: state LOAD, core_run 0, fetch_valid 0, fetch_instr 0, fetch_fault 0, ld_err 0, load_count 0.
- Combinational outputs (ld_ready, mem_we, mem_addr, mem_wdata) follow state and inputs in the same cycle.
- Loader throughput: one word per cycle; no bubble between words.
- LOAD→RUN: core_run rises on the edge that accepts ld_last. The first fetch may be requested in that same following cycle.
- Fetch latency: request in cycle N, fetch_valid/fetch_instr valid after edge N+1.
- Throughput: one fetch per cycle.
- RUN→LOAD: core_run falls and ld_ready rises on the edge after reload_req.
- rst_n asserted mid-load or mid-fetch: immediate return to reset values. Partially loaded memory is left as written.

## Test plan
- Reset, stream 3 words 0x8C100004, 0x02508820, 0x02508822 at byte addresses 0, 4, 8, with ld_last on the third → mem_we high for 3 consecutive cycles with mem_addr 0, 1, 2; load_count = 3; core_run rises on the edge after the third word.
- RUN, pc_addr = 0, 4, 8 on consecutive cycles → fetch_instr = 0x8C100004, 0x02508820, 0x02508822, each one cycle after its request; fetch_valid stays high.
- fetch_hold for 2 cycles during a fetch stream → fetch_instr and fetch_valid frozen; the stream resumes with the address presented after the hold releases.
- pc_addr = 0x6 and pc_addr = 0x1000 → fetch_instr = 0x00000000, fetch_fault = 1; no memory write occurs.
- Loader word at ld_addr = 0x1000 → mem_we = 0, ld_err = 1, load_count unchanged; a following ld_last still moves the block to RUN.
- reload_req in the same cycle as pc_valid, then assert rst_n low mid-load → no fetch result; core_run = 0 and load_count = 0 next cycle. After rst_n is asserted low, all outputs are at reset values immediately, without waiting for a clock edge.
